// File: rtl/alu_multicycle_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding, FSM states, op-class helpers.
// BEQO tests op1 == 1, BEQZ tests op1 == 0; any encoding not listed is an undefined op.
package alu_multicycle_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

  typedef enum logic [4:0] {
    ADD  = 5'd0,  SUB  = 5'd1,  ADDI = 5'd2,  MUL  = 5'd3,
    MULI = 5'd4,  DIV  = 5'd5,  DIVI = 5'd6,  ABS  = 5'd7,
    SLT  = 5'd8,  MIN  = 5'd9,  SEQ  = 5'd10, SEQI = 5'd11,
    SNEZ = 5'd12, BEQO = 5'd13, BEQZ = 5'd14, SLL  = 5'd15,
    SLLI = 5'd16, JAL  = 5'd17
  } alu_instruction_t;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, RESP} alu_state_t;

  function automatic logic is_mul(input alu_instruction_t op);
    return (op == MUL) || (op == MULI);
  endfunction

  function automatic logic is_div(input alu_instruction_t op);
    return (op == DIV) || (op == DIVI);
  endfunction

endpackage

// File: rtl/alu_multicycle_divider.sv
// Restoring radix-2 unsigned divider; the first iteration happens on the start edge,
// so done pulses DATA_WIDTH cycles after start with the final quotient registered.
module alu_divider_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic                  div_by_zero
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dsr_q, dsr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  run_q, run_d, done_q, done_d, dbz_q, dbz_d;

  function automatic logic [2*DATA_WIDTH-1:0] div_step(
    input logic [DATA_WIDTH-1:0] rem,
    input logic [DATA_WIDTH-1:0] quot,
    input logic [DATA_WIDTH-1:0] dsr
  );
    logic [DATA_WIDTH:0] sh;
    logic [DATA_WIDTH:0] diff;
    sh   = {rem, quot[DATA_WIDTH-1]};
    diff = sh - {1'b0, dsr};
    if (diff[DATA_WIDTH]) return {sh[DATA_WIDTH-1:0], quot[DATA_WIDTH-2:0], 1'b0};
    else                  return {diff[DATA_WIDTH-1:0], quot[DATA_WIDTH-2:0], 1'b1};
  endfunction

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    if (start) begin
      {rem_d, quot_d} = div_step('0, dividend, divisor);
      dsr_d = divisor;
      dbz_d = (divisor == '0);
      cnt_d = CW'(1);
      run_d = 1'b1;
    end else if (run_q) begin
      {rem_d, quot_d} = div_step(rem_q, quot_q, dsr_q);
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_WIDTH - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quot_q <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  // A zero divisor leaves the raw quotient meaningless, so report all-ones.
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = dbz_q ? '1 : quot_q;

endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops return next cycle, MUL after MUL_LATENCY, DIV after DATA_WIDTH+1.
// Result is registered and held while out_ready is low.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int PC_WIDTH    = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  alu_instruction_t      in_op,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic [DATA_WIDTH-1:0] in_op2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_div_by_zero,
  output logic                  busy
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int CW  = $clog2(MUL_LATENCY + 1);
  localparam logic [DATA_WIDTH-1:0] SH_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  alu_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  dbz_q, dbz_d;
  logic [CW-1:0]         mul_cnt_q, mul_cnt_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] alu_res, mul_prod, mul_tap, div_quot;
  logic                  div_done, div_dbz;

  assign in_ready        = (state_q == IDLE) || ((state_q == RESP) && out_ready);
  assign accept          = in_valid && in_ready;
  assign out_valid       = (state_q == RESP);
  assign out_result      = result_q;
  assign out_div_by_zero = dbz_q;
  assign busy            = (state_q != IDLE);

  assign mul_prod = in_op1 * ((in_op == MULI) ? in_imm : in_op2);

  // Free-running product chain: the tap is exactly MUL_LATENCY-1 cycles behind the accept.
  generate
    if (MUL_LATENCY == 1) begin : g_mul_comb
      assign mul_tap = mul_prod;
    end else begin : g_mul_pipe
      logic [DATA_WIDTH-1:0] pipe_q [MUL_LATENCY-1];
      always_ff @(posedge clk) begin
        pipe_q[0] <= mul_prod;
        for (int k = 1; k < MUL_LATENCY - 1; k++) pipe_q[k] <= pipe_q[k-1];
      end
      assign mul_tap = pipe_q[MUL_LATENCY-2];
    end
  endgenerate

  alu_divider_iter #(.DATA_WIDTH(DATA_WIDTH)) u_div (
    .clk         (clk),
    .reset       (reset),
    .start       (accept && is_div(in_op)),
    .dividend    (in_op1),
    .divisor     ((in_op == DIVI) ? in_imm : in_op2),
    .done        (div_done),
    .quotient    (div_quot),
    .div_by_zero (div_dbz)
  );

  always_comb begin
    alu_res = '0;
    case (in_op)
      ADD:  alu_res = in_op1 + in_op2;
      SUB:  alu_res = in_op1 - in_op2;
      ADDI: alu_res = in_op1 + in_imm;
      ABS:  alu_res = in_op1[DATA_WIDTH-1] ? (~in_op1 + 1'b1) : in_op1;
      SLT:  alu_res = DATA_WIDTH'(in_op1 < in_op2);
      MIN:  alu_res = (in_op1 < in_op2) ? in_op1 : in_op2;
      SEQ:  alu_res = DATA_WIDTH'(in_op1 == in_op2);
      SEQI: alu_res = DATA_WIDTH'(in_op1 == in_imm);
      SNEZ: alu_res = DATA_WIDTH'(in_op1 != '0);
      BEQO: alu_res = DATA_WIDTH'(in_op1 == DATA_WIDTH'(1));
      BEQZ: alu_res = DATA_WIDTH'(in_op1 == '0);
      SLL:  alu_res = (in_op2 >= SH_LIMIT) ? '0 : (in_op1 << in_op2[SHW-1:0]);
      SLLI: alu_res = in_op1 << in_imm[SHW-1:0];
      JAL:  alu_res = DATA_WIDTH'(in_pc) + in_imm;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    dbz_d     = dbz_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (is_mul(in_op)) begin
            if (MUL_LATENCY == 1) begin
              state_d  = RESP;
              result_d = mul_prod;
              dbz_d    = 1'b0;
            end else begin
              state_d   = MUL_WAIT;
              mul_cnt_d = CW'(MUL_LATENCY - 2);
            end
          end else if (is_div(in_op)) begin
            state_d = DIV_RUN;
          end else begin
            state_d  = RESP;
            result_d = alu_res;
            dbz_d    = 1'b0;
          end
        end else if ((state_q == RESP) && out_ready) begin
          state_d = IDLE;
        end
      end
      MUL_WAIT: begin
        if (mul_cnt_q == '0) begin
          state_d  = RESP;
          result_d = mul_tap;
          dbz_d    = 1'b0;
        end else begin
          mul_cnt_d = mul_cnt_q - CW'(1);
        end
      end
      DIV_RUN: begin
        if (div_done) begin
          state_d  = RESP;
          result_d = div_quot;
          dbz_d    = div_dbz;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      dbz_q     <= 1'b0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (DATA_WIDTH=32, MUL_LATENCY=2): vector table plus
// hand-written sequences for back-to-back issue, output stall and reset during divide.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  alu_instruction_t in_op;
  logic [31:0]      in_pc, in_op1, in_op2, in_imm;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic             out_div_by_zero;
  logic             busy;

  int tests = 0;
  int fails = 0;

  alu_multicycle #(.DATA_WIDTH(32), .PC_WIDTH(32), .MUL_LATENCY(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_op           (in_op),
    .in_pc           (in_pc),
    .in_op1          (in_op1),
    .in_op2          (in_op2),
    .in_imm          (in_imm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_div_by_zero (out_div_by_zero),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_instruction_t op;
    logic [31:0]      op1, op2, imm, pc;
    logic [31:0]      exp_res;
    logic             exp_dbz;
    int               lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input alu_instruction_t op, input logic [31:0] op1, op2, imm, pc,
                              input logic [31:0] res, input logic dbz, input int lat);
    vec_t v;
    v.op = op; v.op1 = op1; v.op2 = op2; v.imm = imm; v.pc = pc;
    v.exp_res = res; v.exp_dbz = dbz; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input alu_instruction_t op, input logic [31:0] op1, op2, imm, pc);
    in_valid = 1'b1; in_op = op; in_op1 = op1; in_op2 = op2; in_imm = imm; in_pc = pc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stale;
    alu_instruction_t undef_op;
    undef_op = alu_instruction_t'(5'h1F);

    vecs.push_back(mk(ADD,  32'h7FFF_FFFF, 32'h1,         32'h0,  32'h0,   32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk(SUB,  32'h5,         32'h7,         32'h0,  32'h0,   32'hFFFF_FFFE, 1'b0, 1));
    vecs.push_back(mk(ADDI, 32'hFFFF_FFFF, 32'h0,         32'h2,  32'h0,   32'h1,         1'b0, 1));
    vecs.push_back(mk(ABS,  32'hFFFF_FFFB, 32'h0,         32'h0,  32'h0,   32'h5,         1'b0, 1));
    vecs.push_back(mk(ABS,  32'h8000_0000, 32'h0,         32'h0,  32'h0,   32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk(ABS,  32'h7,         32'h0,         32'h0,  32'h0,   32'h7,         1'b0, 1));
    vecs.push_back(mk(SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,  32'h0,   32'h1,         1'b0, 1));
    vecs.push_back(mk(SLT,  32'hFFFF_FFFF, 32'h1,         32'h0,  32'h0,   32'h0,         1'b0, 1));
    vecs.push_back(mk(MIN,  32'hFFFF_FFF0, 32'h3,         32'h0,  32'h0,   32'h3,         1'b0, 1));
    vecs.push_back(mk(SEQ,  32'h9,         32'h9,         32'h0,  32'h0,   32'h1,         1'b0, 1));
    vecs.push_back(mk(SEQI, 32'h4,         32'h4,         32'h5,  32'h0,   32'h0,         1'b0, 1));
    vecs.push_back(mk(SNEZ, 32'h0,         32'h0,         32'h0,  32'h0,   32'h0,         1'b0, 1));
    vecs.push_back(mk(SNEZ, 32'h8,         32'h0,         32'h0,  32'h0,   32'h1,         1'b0, 1));
    vecs.push_back(mk(BEQO, 32'h1,         32'h0,         32'h0,  32'h0,   32'h1,         1'b0, 1));
    vecs.push_back(mk(BEQZ, 32'h0,         32'h5,         32'h0,  32'h0,   32'h1,         1'b0, 1));
    vecs.push_back(mk(SLL,  32'h1,         32'd32,        32'h0,  32'h0,   32'h0,         1'b0, 1));
    vecs.push_back(mk(SLL,  32'h1,         32'd31,        32'h0,  32'h0,   32'h8000_0000, 1'b0, 1));
    vecs.push_back(mk(SLLI, 32'h1,         32'h0,         32'h21, 32'h0,   32'h2,         1'b0, 1));
    vecs.push_back(mk(JAL,  32'h0,         32'h0,  32'hFFFF_FFF0, 32'h100, 32'hF0,        1'b0, 1));
    vecs.push_back(mk(undef_op, 32'h12,    32'h34,        32'h56, 32'h78,  32'h0,         1'b0, 1));
    vecs.push_back(mk(MUL,  32'h1_0000,    32'h1_0000,    32'h0,  32'h0,   32'h0,         1'b0, 2));
    vecs.push_back(mk(MULI, 32'h3,         32'h0,  32'hFFFF_FFFE, 32'h0,   32'hFFFF_FFFA, 1'b0, 2));
    vecs.push_back(mk(MUL,  32'd12345,     32'd1000,      32'h0,  32'h0,   32'h00BC_5EA8, 1'b0, 2));
    vecs.push_back(mk(MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,  32'h0,   32'h1,         1'b0, 2));
    vecs.push_back(mk(DIV,  32'd100,       32'd7,         32'h0,  32'h0,   32'd14,        1'b0, 33));
    vecs.push_back(mk(DIVI, 32'd5,         32'd9,         32'h0,  32'h0,   32'hFFFF_FFFF, 1'b1, 33));
    vecs.push_back(mk(DIV,  32'hFFFF_FFFF, 32'h1,         32'h0,  32'h0,   32'hFFFF_FFFF, 1'b0, 33));
    vecs.push_back(mk(DIV,  32'd7,         32'd100,       32'h0,  32'h0,   32'h0,         1'b0, 33));
    vecs.push_back(mk(DIVI, 32'd1000,      32'h0,         32'd3,  32'h0,   32'd333,       1'b0, 33));

    reset = 1'b1; in_valid = 1'b0; in_op = ADD; in_pc = '0;
    in_op1 = '0; in_op2 = '0; in_imm = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_result", out_result, 32'h0);
    check("reset div_by_zero", 32'(out_div_by_zero), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();
    check("post-reset in_ready", 32'(in_ready), 32'h1);

    // Table: latency, in_ready low while busy, held in_valid not consumed, result.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].op1, vecs[i].op2, vecs[i].imm, vecs[i].pc);
      check($sformatf("v%0d in_ready at issue", i), 32'(in_ready), 32'h1);
      tick();
      for (int k = 1; k < vecs[i].lat; k++) begin
        check($sformatf("v%0d out_valid early c%0d", i, k), 32'(out_valid), 32'h0);
        check($sformatf("v%0d in_ready busy c%0d", i, k), 32'(in_ready), 32'h0);
        drive(ADD, $urandom, $urandom, $urandom, $urandom);
        tick();
      end
      in_valid = 1'b0;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("v%0d out_result", i), out_result, vecs[i].exp_res);
      check($sformatf("v%0d div_by_zero", i), 32'(out_div_by_zero), 32'(vecs[i].exp_dbz));
      tick();
      check($sformatf("v%0d idle after", i), 32'(busy), 32'h0);
    end

    // Back-to-back: SUB accepted during ADD's response cycle.
    drive(ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0);
    tick();
    drive(SUB, 32'h5, 32'h7, 32'h0, 32'h0);
    check("b2b add out_valid", 32'(out_valid), 32'h1);
    check("b2b add result", out_result, 32'h8000_0000);
    check("b2b in_ready in RESP", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("b2b sub out_valid", 32'(out_valid), 32'h1);
    check("b2b sub result", out_result, 32'hFFFF_FFFE);
    tick();

    // Output stall with a pending ABS, released in the same cycle it is accepted.
    out_ready = 1'b0;
    drive(SEQ, 32'h9, 32'h9, 32'h0, 32'h0);
    tick();
    drive(ABS, 32'hFFFF_FFFB, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall c%0d out_valid", k), 32'(out_valid), 32'h1);
      check($sformatf("stall c%0d result", k), out_result, 32'h1);
      check($sformatf("stall c%0d in_ready", k), 32'(in_ready), 32'h0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall release in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("abs after stall valid", 32'(out_valid), 32'h1);
    check("abs after stall result", out_result, 32'h5);
    tick();

    // Reset during a divide: in-flight op vanishes without a result.
    drive(DIV, 32'd1000, 32'd3, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("mid-div busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("div reset out_valid", 32'(out_valid), 32'h0);
    check("div reset busy", 32'(busy), 32'h0);
    check("div reset result", out_result, 32'h0);
    check("div reset in_ready", 32'(in_ready), 32'h1);
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid || busy) stale++;
    end
    check("no stale div result", 32'(stale), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
